// File: rtl/spi_flash_read_sched_if.sv
// Command bus between the flash read scheduler and the QSPI read engine.
// master: scheduler side (drives commands); slave: engine side.
interface spi_flash_read_sched_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              eng_cmd_valid;
  logic              eng_cmd_ready;
  logic              eng_cmd_type;
  logic [ADDR_W-1:0] eng_addr;
  logic [4:0]        eng_len;
  logic [1:0]        eng_mode;
  logic [7:0]        eng_die_id;
  logic              eng_done;
  logic              fifo_full;

  modport master (
    output eng_cmd_valid, eng_cmd_type, eng_addr, eng_len, eng_mode, eng_die_id,
    input  eng_cmd_ready, eng_done, fifo_full
  );

  modport slave (
    input  eng_cmd_valid, eng_cmd_type, eng_addr, eng_len, eng_mode, eng_die_id,
    output eng_cmd_ready, eng_done, fifo_full
  );
endinterface

// File: rtl/spi_flash_read_sched.sv
// QSPI flash read command sequencer: splits one inclusive address-range job
// into bursts of at most MAX_BURST bytes that never cross a die boundary,
// inserting die-select commands when requested and throttling on FIFO full.
// Optional watchdog on engine completion: define SFR_SCHED_TIMEOUT_EN.
module spi_flash_read_sched #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DIE_SIZE_LOG2 = 25,
  parameter int unsigned MAX_BURST     = 16,
  parameter int unsigned TIMEOUT_CYC   = 4096
) (
  input  logic                  system_clk,
  input  logic                  system_reset_n,
  input  logic                  read_req,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  input  logic [1:0]            mode,
  input  logic                  switch_die_need,
  output logic                  busy,
  output logic                  completed,
  output logic                  error,
  spi_flash_read_sched_if.master eng_if
);

  typedef enum logic [2:0] {
    IDLE, CHECK, DIE_SEL, WAIT_DIE, ISSUE, WAIT_RD, NEXT, DONE
  } state_t;

  state_t              st, st_nxt;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   end_q;
  logic [1:0]          mode_q;
  logic                sw_q;
  logic [ADDR_W:0]     remaining;
  logic [ADDR_W:0]     die_room;
  logic [ADDR_W:0]     len_w;
  logic [4:0]          len_c;
  logic [4:0]          len_q;
  logic [ADDR_W+7:0]   addr_ext;
  logic                job_ok_in;
  logic                job_ok_q;
  logic                hs;
  logic                tmo;

  assign job_ok_in = (end_addr >= start_addr) && (mode != 2'b11);
  assign job_ok_q  = (end_q >= cur_addr) && (mode_q != 2'b11);

  assign eng_if.eng_cmd_valid = (st == DIE_SEL) || ((st == ISSUE) && !eng_if.fifo_full);
  assign eng_if.eng_cmd_type  = (st == DIE_SEL);
  assign eng_if.eng_addr      = cur_addr;
  assign eng_if.eng_len       = (st == ISSUE) ? len_c : '0;
  assign eng_if.eng_mode      = mode_q;
  // Die id may extend past the top address bit; zero-extend before slicing.
  assign addr_ext             = {8'h00, cur_addr};
  assign eng_if.eng_die_id    = addr_ext[DIE_SIZE_LOG2+7 -: 8];
  assign hs                   = eng_if.eng_cmd_valid && eng_if.eng_cmd_ready;

  // Burst length: smallest of MAX_BURST, bytes left, bytes left in this die.
  always_comb begin
    die_room = '0;
    die_room[DIE_SIZE_LOG2] = 1'b1;
    die_room = die_room - (ADDR_W+1)'(cur_addr[DIE_SIZE_LOG2-1:0]);
    len_w = (ADDR_W+1)'(MAX_BURST);
    if (remaining < len_w) len_w = remaining;
    if (die_room < len_w) len_w = die_room;
    len_c = len_w[4:0];
  end

`ifdef SFR_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic          waiting;

  assign waiting = (st == WAIT_DIE) || (st == WAIT_RD);
  assign tmo     = waiting && !eng_if.eng_done && (tcnt == TW'(TIMEOUT_CYC - 1));

  // Watchdog counter: restarts on every state change, counts while waiting on the engine.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n)   tcnt <= '0;
    else if (st_nxt != st) tcnt <= '0;
    else if (waiting)      tcnt <= tcnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) st <= IDLE;
    else                 st <= st_nxt;
  end

  // Next-state logic.
  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:     if (read_req) st_nxt = CHECK;
      CHECK:    if (!job_ok_q) st_nxt = IDLE;
                else if (sw_q) st_nxt = DIE_SEL;
                else           st_nxt = ISSUE;
      DIE_SEL:  if (eng_if.eng_cmd_ready) st_nxt = WAIT_DIE;
      WAIT_DIE: if (eng_if.eng_done) st_nxt = ISSUE;
      ISSUE:    if (hs) st_nxt = WAIT_RD;
      WAIT_RD:  if (eng_if.eng_done) st_nxt = NEXT;
      NEXT:     if (remaining == '0) st_nxt = DONE;
                else if (sw_q && (cur_addr[DIE_SIZE_LOG2-1:0] == '0)) st_nxt = DIE_SEL;
                else st_nxt = ISSUE;
      DONE:     st_nxt = IDLE;
      default:  st_nxt = IDLE;
    endcase
    if (tmo) st_nxt = IDLE;
  end

  // Job registers and status flags.
  // busy is only raised for jobs that will pass the CHECK stage, so a
  // rejected job reports error without ever showing busy.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      cur_addr  <= '0;
      end_q     <= '0;
      mode_q    <= '0;
      sw_q      <= 1'b0;
      remaining <= '0;
      len_q     <= '0;
      busy      <= 1'b0;
      completed <= 1'b0;
      error     <= 1'b0;
    end else begin
      error <= 1'b0;
      unique case (st)
        IDLE: if (read_req) begin
          cur_addr  <= start_addr;
          end_q     <= end_addr;
          mode_q    <= mode;
          sw_q      <= switch_die_need;
          completed <= 1'b0;
          busy      <= job_ok_in;
        end
        CHECK: begin
          if (!job_ok_q) begin
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            remaining <= {1'b0, end_q} - {1'b0, cur_addr} + (ADDR_W+1)'(1);
          end
        end
        ISSUE: if (hs) len_q <= len_c;
        WAIT_RD: if (eng_if.eng_done) begin
          cur_addr  <= cur_addr + ADDR_W'(len_q);
          remaining <= remaining - (ADDR_W+1)'(len_q);
        end
        NEXT: if (remaining == '0) begin
          busy      <= 1'b0;
          completed <= 1'b1;
        end
        default: ;
      endcase
      if (tmo) begin
        error     <= 1'b1;
        busy      <= 1'b0;
        completed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_read_sched.sv
// Directed bench for spi_flash_read_sched: hand-computed command sequences
// for burst splitting, die selects, FIFO throttling, rejects and reset.
module tb_spi_flash_read_sched;

  logic        system_clk = 1'b0;
  logic        system_reset_n = 1'b0;
  logic        read_req = 1'b0;
  logic [31:0] start_addr = '0;
  logic [31:0] end_addr = '0;
  logic [1:0]  mode = '0;
  logic        switch_die_need = 1'b0;
  logic        busy, completed, error;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  spi_flash_read_sched_if #(.ADDR_W(32)) bus ();

  spi_flash_read_sched #(
    .ADDR_W(32), .DIE_SIZE_LOG2(25), .MAX_BURST(16), .TIMEOUT_CYC(64)
  ) dut (
    .system_clk      (system_clk),
    .system_reset_n  (system_reset_n),
    .read_req        (read_req),
    .start_addr      (start_addr),
    .end_addr        (end_addr),
    .mode            (mode),
    .switch_die_need (switch_die_need),
    .busy            (busy),
    .completed       (completed),
    .error           (error),
    .eng_if          (bus)
  );

  always #5 system_clk = ~system_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] e,
                           input logic [1:0] m, input logic sw);
    @(negedge system_clk);
    start_addr = s; end_addr = e; mode = m; switch_die_need = sw;
    read_req = 1'b1;
    @(negedge system_clk);
    read_req = 1'b0;
  endtask

  // Wait for a command, check its fields, accept it with one ready cycle.
  task automatic take_cmd(input string tag, input logic typ, input logic [31:0] addr,
                          input logic [4:0] len, input logic [7:0] die, input logic [1:0] m);
    int k = 0;
    while (bus.eng_cmd_valid !== 1'b1 && k < 100) begin
      @(negedge system_clk);
      k++;
    end
    chk({tag, " valid"}, bus.eng_cmd_valid, 1);
    chk({tag, " type"}, bus.eng_cmd_type, typ);
    chk({tag, " mode"}, bus.eng_mode, m);
    if (typ) chk({tag, " die"}, bus.eng_die_id, die);
    else begin
      chk({tag, " addr"}, bus.eng_addr, addr);
      chk({tag, " len"}, bus.eng_len, len);
    end
    bus.eng_cmd_ready = 1'b1;
    @(negedge system_clk);
    bus.eng_cmd_ready = 1'b0;
    chk({tag, " valid drop"}, bus.eng_cmd_valid, 0);
  endtask

  task automatic pulse_done();
    @(negedge system_clk);
    bus.eng_done = 1'b1;
    @(negedge system_clk);
    bus.eng_done = 1'b0;
  endtask

  task automatic cmd(input string tag, input logic typ, input logic [31:0] addr,
                     input logic [4:0] len, input logic [7:0] die, input logic [1:0] m);
    take_cmd(tag, typ, addr, len, die, m);
    @(negedge system_clk);
    pulse_done();
  endtask

  // Completion appears one clock after the final eng_done is sampled.
  task automatic expect_completed(input string tag);
    chk({tag, " busy tail"}, busy, 1);
    @(negedge system_clk);
    chk({tag, " completed"}, completed, 1);
    chk({tag, " busy end"}, busy, 0);
    @(negedge system_clk);
    @(negedge system_clk);
    chk({tag, " completed held"}, completed, 1);
    chk({tag, " no extra cmd"}, bus.eng_cmd_valid, 0);
  endtask

  initial begin
    int nvalid;
    bus.eng_cmd_ready = 1'b0;
    bus.eng_done = 1'b0;
    bus.fifo_full = 1'b0;
    repeat (3) @(negedge system_clk);
    chk("reset busy", busy, 0);
    chk("reset completed", completed, 0);
    chk("reset error", error, 0);
    chk("reset valid", bus.eng_cmd_valid, 0);
    system_reset_n = 1'b1;

    // Single mode, 0x0..0x10: 16 + 1 bytes.
    start_job(32'h0, 32'h10, 2'b00, 1'b0);
    chk("t1 busy", busy, 1);
    cmd("t1 b0", 1'b0, 32'h0, 5'd16, 8'd0, 2'b00);
    cmd("t1 b1", 1'b0, 32'h10, 5'd1, 8'd0, 2'b00);
    expect_completed("t1");

    // Quad mode, single full burst.
    start_job(32'h200, 32'h20F, 2'b10, 1'b0);
    chk("t2 busy", busy, 1);
    chk("t2 completed cleared", completed, 0);
    cmd("t2 b0", 1'b0, 32'h200, 5'd16, 8'd0, 2'b10);
    expect_completed("t2");

    // Die switch across 0x02000000: 16 + 16 + 1 bytes with two die selects.
    start_job(32'h01FF_FFF0, 32'h0200_0010, 2'b01, 1'b1);
    cmd("t3 ds0", 1'b1, 32'h0, 5'd0, 8'd0, 2'b01);
    cmd("t3 b0", 1'b0, 32'h01FF_FFF0, 5'd16, 8'd0, 2'b01);
    cmd("t3 ds1", 1'b1, 32'h0, 5'd0, 8'd1, 2'b01);
    cmd("t3 b1", 1'b0, 32'h0200_0000, 5'd16, 8'd1, 2'b01);
    cmd("t3 b2", 1'b0, 32'h0200_0010, 5'd1, 8'd1, 2'b01);
    expect_completed("t3");

    // Die boundary split without die-select commands.
    start_job(32'h01FF_FFF8, 32'h0200_0003, 2'b00, 1'b0);
    cmd("t3b b0", 1'b0, 32'h01FF_FFF8, 5'd8, 8'd0, 2'b00);
    cmd("t3b b1", 1'b0, 32'h0200_0000, 5'd4, 8'd0, 2'b00);
    expect_completed("t3b");

    // FIFO full hold after the first burst.
    start_job(32'h300, 32'h31F, 2'b00, 1'b0);
    take_cmd("t4 b0", 1'b0, 32'h300, 5'd16, 8'd0, 2'b00);
    @(negedge system_clk);
    bus.eng_done = 1'b1;
    bus.fifo_full = 1'b1;
    @(negedge system_clk);
    bus.eng_done = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.eng_cmd_valid) nvalid++;
      @(negedge system_clk);
    end
    chk("t4 no valid while full", nvalid, 0);
    bus.fifo_full = 1'b0;
    #1;
    chk("t4 valid on release", bus.eng_cmd_valid, 1);
    bus.fifo_full = 1'b1;
    #1;
    chk("t4 valid withdrawn", bus.eng_cmd_valid, 0);
    @(negedge system_clk);
    bus.fifo_full = 1'b0;
    cmd("t4 b1", 1'b0, 32'h310, 5'd16, 8'd0, 2'b00);
    expect_completed("t4");

    // Top of address space and one-byte job.
    start_job(32'hFFFF_FFF8, 32'hFFFF_FFFF, 2'b10, 1'b0);
    cmd("t5 top", 1'b0, 32'hFFFF_FFF8, 5'd8, 8'd0, 2'b10);
    expect_completed("t5");
    start_job(32'h400, 32'h400, 2'b01, 1'b0);
    cmd("t5 one", 1'b0, 32'h400, 5'd1, 8'd0, 2'b01);
    expect_completed("t5b");

    // Rejected jobs: end < start, reserved mode.
    start_job(32'h100, 32'hFF, 2'b00, 1'b0);
    chk("t6 busy never", busy, 0);
    chk("t6 completed cleared", completed, 0);
    @(negedge system_clk);
    chk("t6 error", error, 1);
    chk("t6 busy", busy, 0);
    @(negedge system_clk);
    chk("t6 error pulse", error, 0);
    start_job(32'h100, 32'h1FF, 2'b11, 1'b0);
    chk("t7 busy never", busy, 0);
    @(negedge system_clk);
    chk("t7 error", error, 1);
    @(negedge system_clk);
    chk("t7 error pulse", error, 0);
    chk("t7 no cmd", bus.eng_cmd_valid, 0);

    // Reset while waiting on a read burst.
    start_job(32'h500, 32'h50F, 2'b10, 1'b0);
    take_cmd("t8 b0", 1'b0, 32'h500, 5'd16, 8'd0, 2'b10);
    system_reset_n = 1'b0;
    #1;
    chk("t8 busy", busy, 0);
    chk("t8 completed", completed, 0);
    chk("t8 error", error, 0);
    chk("t8 mode", bus.eng_mode, 0);
    chk("t8 addr", bus.eng_addr, 0);
    @(negedge system_clk);
    system_reset_n = 1'b1;
    start_job(32'h600, 32'h603, 2'b01, 1'b0);
    cmd("t8 after", 1'b0, 32'h600, 5'd4, 8'd0, 2'b01);
    expect_completed("t8");

`ifdef SFR_SCHED_TIMEOUT_EN
    // Withheld eng_done: error 64 cycles after entering WAIT_RD.
    start_job(32'h700, 32'h70F, 2'b00, 1'b0);
    take_cmd("t9 b0", 1'b0, 32'h700, 5'd16, 8'd0, 2'b00);
    repeat (63) @(negedge system_clk);
    chk("t9 no early error", error, 0);
    chk("t9 busy before", busy, 1);
    @(negedge system_clk);
    chk("t9 error", error, 1);
    chk("t9 busy", busy, 0);
    chk("t9 completed", completed, 0);
    @(negedge system_clk);
    chk("t9 error pulse", error, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
